arith_machine_mc: RTL and testbench
===================================

Name: arith_machine_mc

Overview:
Parametrised multi-cycle successor to the single-cycle arithmetic machine.
- Fetches MIPS-encoded arithmetic instructions from an external instruction memory over a req/valid handshake.
- Decodes each instruction, executes it in the ALU, writes the register file and advances the PC.
- Raises a sticky exception on any unsupported or out-of-range instruction, then halts.
- Sits between the instruction-memory model and the test bench; a later step extends it into the full datapath.

Parameters:
WIDTH, 32, datapath/register width in bits (16..32); immediates are extended to WIDTH.
NREGS, 32, number of architectural registers (power of two, 2..32).
PC_RESET, 32'h00400000, PC value loaded on reset.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high; clears all state.
imem_req  out  1  fetch request; high exactly while the FSM is in FETCH.
imem_addr  out  32  byte address of the requested instruction (= PC).
imem_valid  in  1  instruction memory has driven imem_data this cycle.
imem_data  in  32  instruction word; sampled only when imem_req & imem_valid.
except  out  1  sticky; unrecognised instruction encountered.
halted  out  1  machine stopped (TRAP state).
retired  out  32  count of completed instructions; wraps modulo 2^32.
dbg_pc  out  32  current PC.

Behaviour:
- One clock, named clock. Reset is synchronous and active-high (port reset). All state updates on the rising edge of clock.
- Reset values: state=FETCH, PC=PC_RESET, all registers=0, IR=0, except=0, halted=0, retired=0. imem_req is therefore 1 in the first cycle after reset.
- FETCH state:
  - imem_req=1 and imem_addr=PC, both held stable.
  - On imem_valid=1, IR<=imem_data and the FSM moves to DECODE. Otherwise it stays in FETCH.
  - imem_valid is ignored in every other state.
- DECODE state:
  - Read rs/rt from the register file and classify IR.
  - Legal instruction -> EXEC. Illegal -> TRAP, with except<=1 and halted<=1 on that edge.
- EXEC state:
  - Result is written to rd (R-type) or rt (I-type).
  - PC<=PC+4 (32-bit wrap); retired<=retired+1; next state FETCH.
- TRAP state: terminal. imem_req=0, PC/registers/retired frozen, except=halted=1 until reset.
- Minimum latency is 3 cycles per instruction (FETCH with same-cycle valid, DECODE, EXEC). Each cycle imem_valid is late adds one cycle.
- Legal R-type (opcode 0), by funct:
  - add 0x20, sub 0x22: two's-complement, wrap, no overflow trap.
  - and 0x24, or 0x25, xor 0x26, nor 0x27.
  - shamt must be 0, otherwise illegal.
- Legal I-type:
  - addi 0x08: sign-extended imm16.
  - andi 0x0C, ori 0x0D, xori 0x0E: zero-extended imm16.
- Illegal: every other opcode/funct, and any rs/rt/rd field >= NREGS. Register fields are checked only for fields the instruction uses.
- Register 0 reads as 0. Writes to register 0 are dropped and are not an exception.
- Reset asserted in any state (mid-FETCH, DECODE, EXEC, TRAP) wins: no register write or retire is committed on that edge.
- A reset while TRAP'd clears except/halted.

Decomposition:
- Package arith_mc_pkg holds:
  - opcode/funct constants;
  - the ALU-op enum (3-bit, same encoding as the existing 32-bit ALU);
  - the FSM state enum {FETCH, DECODE, EXEC, TRAP};
  - the default PC_RESET.
- One sub-module: regfile_p, a parametrised (WIDTH, NREGS) 2-read/1-write register file with combinational reads, synchronous write, register 0 hardwired to zero and synchronous reset to 0.
- The decoder and ALU stay inline.

Test Plan:
1. Reset, imem_valid tied 1, word 0x20010005 (addi $1,$0,5) -> after 3 cycles r1=5, dbg_pc=0x00400004, retired=1, except=0.
2. r1=0x7FFFFFFF, r2=1, then add $3,$1,$2 (0x00221820) -> r3=0x80000000, except=0 (wrap). Also ori $2,$0,0xFFFF -> r2=0x0000FFFF, and addi $2,$0,-1 -> r2=0xFFFFFFFF.
3. Hold imem_valid=0 for 4 cycles after the request -> imem_req=1 and imem_addr constant throughout; retired unchanged; the instruction completes 2 cycles after valid rises.
4. Word 0x8C010000 (lw) -> except=halted=1 one cycle after DECODE. Then imem_req=0, dbg_pc unchanged, and registers unchanged for 20 cycles.
5. addi $0,$0,7 -> r0 reads 0, except=0, retired increments. With NREGS=16, add $20,$1,$2 -> except=1.
6. Assert reset during EXEC of addi $5,$0,9 -> r5=0, retired=0, dbg_pc=0x00400000, state FETCH. Program then re-executes correctly.

Source files
------------

// File: rtl/arith_mc_pkg.sv
// Shared encodings, ALU op codes and FSM states for the multi-cycle arithmetic machine.
package arith_mc_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0040_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_XOR = 3'b011,
    ALU_NOR = 3'b100,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_TRAP   = 2'd3
  } state_e;

  // A 5-bit register field is usable only if it names an implemented register.
  function automatic logic reg_in_range(input logic [4:0] idx, input int nregs);
    return ({27'd0, idx} < 32'(nregs));
  endfunction

endpackage

// File: rtl/regfile_p.sv
// Parametrised 2-read/1-write register file; register 0 is hardwired to zero.
module regfile_p #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [$clog2(NREGS)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(NREGS)-1:0] raddr_a_i,
  input  logic [$clog2(NREGS)-1:0] raddr_b_i,
  output logic [WIDTH-1:0]         rdata_a_o,
  output logic [WIDTH-1:0]         rdata_b_o
);

  logic [WIDTH-1:0] regs_q [NREGS];

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];

  // Reset has priority over a pending write; writes to register 0 are dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/arith_machine_mc.sv
// Multi-cycle FETCH/DECODE/EXEC machine for MIPS arithmetic instructions with a
// sticky trap on anything it does not implement.
module arith_machine_mc
  import arith_mc_pkg::*;
#(
  parameter int          WIDTH    = 32,
  parameter int          NREGS    = 32,
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_data,
  output logic        except,
  output logic        halted,
  output logic [31:0] retired,
  output logic [31:0] dbg_pc
);

  localparam int AW = $clog2(NREGS);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic        req_q;
  logic        except_q;
  logic        halted_q;
  logic [31:0] retired_q;

  logic [5:0]  opcode_s;
  logic [4:0]  rs_s;
  logic [4:0]  rt_s;
  logic [4:0]  rd_s;
  logic [4:0]  shamt_s;
  logic [5:0]  funct_s;
  logic [15:0] imm_s;

  alu_op_e     alu_op_s;
  logic        use_imm_s;
  logic        sext_s;
  logic        op_ok_s;
  logic        uses_rd_s;
  logic        legal_s;
  logic [4:0]  dst_s;

  logic [WIDTH-1:0] imm_ext_s;
  logic [WIDTH-1:0] rs_data_s;
  logic [WIDTH-1:0] rt_data_s;
  logic [WIDTH-1:0] opb_s;
  logic [WIDTH-1:0] wb_data_s;

  assign opcode_s = ir_q[31:26];
  assign rs_s     = ir_q[25:21];
  assign rt_s     = ir_q[20:16];
  assign rd_s     = ir_q[15:11];
  assign shamt_s  = ir_q[10:6];
  assign funct_s  = ir_q[5:0];
  assign imm_s    = ir_q[15:0];

  // Classify the held instruction; IR is stable through DECODE and EXEC.
  always_comb begin
    alu_op_s  = ALU_ADD;
    use_imm_s = 1'b0;
    sext_s    = 1'b0;
    op_ok_s   = 1'b0;
    uses_rd_s = 1'b0;
    case (opcode_s)
      OP_RTYPE: begin
        uses_rd_s = 1'b1;
        case (funct_s)
          FN_ADD:  begin alu_op_s = ALU_ADD; op_ok_s = 1'b1; end
          FN_SUB:  begin alu_op_s = ALU_SUB; op_ok_s = 1'b1; end
          FN_AND:  begin alu_op_s = ALU_AND; op_ok_s = 1'b1; end
          FN_OR:   begin alu_op_s = ALU_OR;  op_ok_s = 1'b1; end
          FN_XOR:  begin alu_op_s = ALU_XOR; op_ok_s = 1'b1; end
          FN_NOR:  begin alu_op_s = ALU_NOR; op_ok_s = 1'b1; end
          default: begin alu_op_s = ALU_ADD; op_ok_s = 1'b0; end
        endcase
      end
      OP_ADDI: begin alu_op_s = ALU_ADD; use_imm_s = 1'b1; sext_s = 1'b1; op_ok_s = 1'b1; end
      OP_ANDI: begin alu_op_s = ALU_AND; use_imm_s = 1'b1; op_ok_s = 1'b1; end
      OP_ORI:  begin alu_op_s = ALU_OR;  use_imm_s = 1'b1; op_ok_s = 1'b1; end
      OP_XORI: begin alu_op_s = ALU_XOR; use_imm_s = 1'b1; op_ok_s = 1'b1; end
      default: begin op_ok_s = 1'b0; end
    endcase
  end

  // rs and rt are used by every legal form; rd and shamt only by R-type.
  assign legal_s = op_ok_s
                   && (!uses_rd_s || (shamt_s == 5'd0))
                   && reg_in_range(rs_s, NREGS)
                   && reg_in_range(rt_s, NREGS)
                   && (!uses_rd_s || reg_in_range(rd_s, NREGS));
  assign dst_s   = uses_rd_s ? rd_s : rt_s;

  // Works down to WIDTH=16, where there are no upper bits to fill.
  always_comb begin
    imm_ext_s        = {WIDTH{sext_s & imm_s[15]}};
    imm_ext_s[15:0]  = imm_s;
  end

  assign opb_s = use_imm_s ? imm_ext_s : rt_data_s;

  // ALU: add/sub wrap silently, no overflow detection.
  always_comb begin
    case (alu_op_s)
      ALU_ADD: wb_data_s = rs_data_s + opb_s;
      ALU_SUB: wb_data_s = rs_data_s - opb_s;
      ALU_AND: wb_data_s = rs_data_s & opb_s;
      ALU_OR:  wb_data_s = rs_data_s | opb_s;
      ALU_XOR: wb_data_s = rs_data_s ^ opb_s;
      ALU_NOR: wb_data_s = ~(rs_data_s | opb_s);
      default: wb_data_s = '0;
    endcase
  end

  regfile_p #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_rf (
    .clk_i     (clock),
    .rst_i     (reset),
    .we_i      (state_q == ST_EXEC),
    .waddr_i   (dst_s[AW-1:0]),
    .wdata_i   (wb_data_s),
    .raddr_a_i (rs_s[AW-1:0]),
    .raddr_b_i (rt_s[AW-1:0]),
    .rdata_a_o (rs_data_s),
    .rdata_b_o (rt_data_s)
  );

  // Control FSM; imem_req is registered so it is high exactly while in FETCH.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      pc_q      <= PC_RESET;
      ir_q      <= 32'd0;
      req_q     <= 1'b1;
      except_q  <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= 32'd0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imem_valid) begin
            ir_q    <= imem_data;
            req_q   <= 1'b0;
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (legal_s) begin
            state_q <= ST_EXEC;
          end else begin
            state_q  <= ST_TRAP;
            except_q <= 1'b1;
            halted_q <= 1'b1;
          end
        end
        ST_EXEC: begin
          pc_q      <= pc_q + 32'd4;
          retired_q <= retired_q + 32'd1;
          req_q     <= 1'b1;
          state_q   <= ST_FETCH;
        end
        ST_TRAP: begin
          req_q <= 1'b0;
        end
        default: begin
          state_q  <= ST_TRAP;
          req_q    <= 1'b0;
          except_q <= 1'b1;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign dbg_pc    = pc_q;
  assign except    = except_q;
  assign halted    = halted_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_arith_machine_mc.sv
// Scoreboard bench: the driver queues the expected outcome of each instruction,
// a monitor pops and compares whenever the machine retires or traps.
module tb_arith_machine_mc;

  localparam logic [31:0] PCR = 32'h0040_0000;

  typedef struct {
    logic [31:0] ret;
    logic [31:0] pc;
    int          cyc;
    logic        exc;
    bit          chk_reg;
    int          ridx;
    logic [31:0] rval;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic        except;
  logic        halted;
  logic [31:0] retired;
  logic [31:0] dbg_pc;

  logic        reset16;
  logic        req16;
  logic [31:0] addr16;
  logic        valid16;
  logic [31:0] data16;
  logic        except16;
  logic        halted16;
  logic [31:0] retired16;
  logic [31:0] pc16;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  exp_t        sbq[$];
  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic [31:0] last_ret = 32'd0;
  logic        last_halt = 1'b0;

  arith_machine_mc u_dut (
    .clock      (clock),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_data  (imem_data),
    .except     (except),
    .halted     (halted),
    .retired    (retired),
    .dbg_pc     (dbg_pc)
  );

  arith_machine_mc #(.NREGS(16)) u_dut16 (
    .clock      (clock),
    .reset      (reset16),
    .imem_req   (req16),
    .imem_addr  (addr16),
    .imem_valid (valid16),
    .imem_data  (data16),
    .except     (except16),
    .halted     (halted16),
    .retired    (retired16),
    .dbg_pc     (pc16)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rf(input int i);
    return u_dut.u_rf.regs_q[i];
  endfunction

  // Monitor: every retire or trap must match the oldest queued expectation.
  always @(negedge clock) begin
    exp_t e;
    if ((retired === last_ret + 32'd1) || (halted === 1'b1 && last_halt === 1'b0)) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event retired=0x%08h halted=%0b", retired, halted);
      end else begin
        e = sbq.pop_front();
        chk("retired", retired, e.ret);
        chk("dbg_pc", dbg_pc, e.pc);
        chk("except", 32'(except), 32'(e.exc));
        chk("halted", 32'(halted), 32'(e.exc));
        chk("latency", 32'(cyc), 32'(e.cyc));
        if (e.chk_reg) chk($sformatf("reg%0d", e.ridx), rf(e.ridx), e.rval);
      end
    end
    last_ret  = retired;
    last_halt = halted;
  end

  task automatic drive(input logic [31:0] word, input int delay, input bit push,
                       input exp_t e, input int lat);
    int n;
    logic [31:0] a0;
    logic [31:0] r0;
    n = 0;
    while (imem_req !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("req_seen", 32'(imem_req), 32'd1);
    chk("fetch_addr", imem_addr, m_pc);
    a0 = imem_addr;
    r0 = retired;
    for (int i = 0; i < delay; i++) begin
      imem_valid = 1'b0;
      @(negedge clock);
      chk("stall_req", 32'(imem_req), 32'd1);
      chk("stall_addr", imem_addr, a0);
      chk("stall_retired", retired, r0);
    end
    if (push) begin
      e.cyc = cyc + lat;
      sbq.push_back(e);
    end
    imem_valid = 1'b1;
    imem_data  = word;
    @(negedge clock);
    imem_valid = 1'b0;
    imem_data  = 32'hDEAD_BEEF;
  endtask

  task automatic issue(input logic [31:0] word, input int delay, input int ridx,
                       input logic [31:0] rval);
    exp_t e;
    e.ret = m_ret + 32'd1; e.pc = m_pc + 32'd4; e.exc = 1'b0;
    e.chk_reg = 1'b1; e.ridx = ridx; e.rval = rval; e.cyc = 0;
    drive(word, delay, 1'b1, e, 3);
    m_ret = m_ret + 32'd1;
    m_pc  = m_pc + 32'd4;
  endtask

  task automatic issue_trap(input logic [31:0] word);
    exp_t e;
    e.ret = m_ret; e.pc = m_pc; e.exc = 1'b1;
    e.chk_reg = 1'b0; e.ridx = 0; e.rval = 32'd0; e.cyc = 0;
    drive(word, 0, 1'b1, e, 2);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
  endtask

  task automatic do_reset();
    imem_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    m_pc  = PCR;
    m_ret = 32'd0;
    chk("rst_req", 32'(imem_req), 32'd1);
    chk("rst_addr", imem_addr, PCR);
    chk("rst_pc", dbg_pc, PCR);
    chk("rst_except", 32'(except), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_r1", rf(1), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t dummy;
    dummy = '{ret: 32'd0, pc: 32'd0, cyc: 0, exc: 1'b0, chk_reg: 1'b0, ridx: 0, rval: 32'd0};
    imem_data = 32'd0;
    reset16 = 1'b1;
    valid16 = 1'b1;
    data16  = 32'h200F_0003;
    do_reset();

    // addi $1,$0,5 with memory answering immediately
    issue(32'h2001_0005, 0, 1, 32'd5);
    wait_idle();
    chk("t1_pc", dbg_pc, 32'h0040_0004);
    chk("t1_retired", retired, 32'd1);

    // build 0x7FFFFFFF in r1 by doubling 0x8000 sixteen times, then subtract one
    issue(32'h3401_8000, 0, 1, 32'h0000_8000);
    for (int k = 0; k < 16; k++) begin
      issue(32'h0021_0820, (k == 5) ? 2 : 0, 1, 32'h0000_8000 << (k + 1));
    end
    issue(32'h2021_FFFF, 1, 1, 32'h7FFF_FFFF);
    issue(32'h2002_0001, 0, 2, 32'd1);
    issue(32'h0022_1820, 0, 3, 32'h8000_0000);
    issue(32'h3402_FFFF, 0, 2, 32'h0000_FFFF);
    issue(32'h2002_FFFF, 0, 2, 32'hFFFF_FFFF);
    issue(32'h0041_2022, 0, 4, 32'h8000_0000);
    issue(32'h0023_2824, 0, 5, 32'h0000_0000);
    issue(32'h0023_2825, 0, 5, 32'hFFFF_FFFF);
    issue(32'h0043_3026, 0, 6, 32'h7FFF_FFFF);
    issue(32'h0060_3827, 0, 7, 32'h7FFF_FFFF);
    issue(32'h3048_8001, 0, 8, 32'h0000_8001);
    issue(32'h3849_00F0, 0, 9, 32'hFFFF_FF0F);
    issue(32'h0040_A020, 0, 20, 32'hFFFF_FFFF);
    issue(32'h2000_0007, 0, 0, 32'd0);
    issue(32'h2006_0003, 4, 6, 32'd3);
    wait_idle();

    // reset lands on the EXEC edge of addi $5,$0,9: nothing may commit
    drive(32'h2005_0009, 0, 1'b0, dummy, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    m_pc  = PCR;
    m_ret = 32'd0;
    chk("t6_r5", rf(5), 32'd0);
    chk("t6_retired", retired, 32'd0);
    chk("t6_pc", dbg_pc, PCR);
    chk("t6_req", 32'(imem_req), 32'd1);
    issue(32'h2005_0009, 0, 5, 32'd9);
    wait_idle();
    chk("t6_pc_after", dbg_pc, 32'h0040_0004);

    // lw traps; machine must stay frozen and ignore further valid words
    issue(32'h2001_0005, 0, 1, 32'd5);
    issue_trap(32'h8C01_0000);
    wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (i == 3) begin
        imem_valid = 1'b1;
        imem_data  = 32'h2001_0063;
      end
      @(negedge clock);
      chk("trap_req", 32'(imem_req), 32'd0);
      chk("trap_pc", dbg_pc, m_pc);
      chk("trap_retired", retired, m_ret);
      chk("trap_halted", 32'(halted), 32'd1);
      chk("trap_r1", rf(1), 32'd5);
    end
    imem_valid = 1'b0;
    do_reset();

    // nonzero shamt on add is illegal and must not write rd
    issue(32'h2001_0005, 0, 1, 32'd5);
    issue(32'h2002_0001, 0, 2, 32'd1);
    issue_trap(32'h0022_1860);
    wait_idle();
    chk("shamt_r3", rf(3), 32'd0);
    do_reset();

    // unsupported funct (slt)
    issue_trap(32'h0022_182A);
    wait_idle();
    do_reset();

    // 16-register instance: rd/rs fields above 15 trap
    @(negedge clock);
    reset16 = 1'b0;
    repeat (3) @(negedge clock);
    chk("n16_retired", retired16, 32'd1);
    chk("n16_r15", u_dut16.u_rf.regs_q[15], 32'd3);
    chk("n16_except0", 32'(except16), 32'd0);
    chk("n16_pc", pc16, 32'h0040_0004);
    data16 = 32'h0022_A020;
    repeat (2) @(negedge clock);
    chk("n16_rd20_except", 32'(except16), 32'd1);
    chk("n16_rd20_halted", 32'(halted16), 32'd1);
    chk("n16_rd20_retired", retired16, 32'd1);
    chk("n16_rd20_req", 32'(req16), 32'd0);
    chk("n16_rd20_addr", addr16, 32'h0040_0004);
    reset16 = 1'b1;
    data16  = 32'h2221_0000;
    @(negedge clock);
    reset16 = 1'b0;
    chk("n16_rst_except", 32'(except16), 32'd0);
    repeat (2) @(negedge clock);
    chk("n16_rs17_except", 32'(except16), 32'd1);
    chk("n16_rs17_retired", retired16, 32'd0);

    repeat (3) @(negedge clock);
    chk("final_queue_empty", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
